// File: rtl/seq_counter_gen.sv
// -----------------------------------------------------------------------------
// seq_counter_gen
//
// Arbitrary-order sequence counter. A runtime-programmable table of WIDTH-bit
// codes is stepped through forward or in reverse over the first 'len' entries.
// This generalises the classic fixed-order T-flip-flop sequence counter.
//
// Optional feature (macro SEQ_TOGGLE_OUT_EN):
//   Adds port t_out = q ^ (code selected by the next en step with the current
//   dir). This is the toggle vector a T-flip-flop implementation would need.
//   t_out is forced to 0 when len == 1.
//
// Ports:
//   clk         rising-edge clock
//   rst         synchronous active-high reset (overrides everything)
//   en          advance one step this edge
//   dir         0 = forward (idx+1), 1 = reverse (idx-1)
//   load        jump idx to load_idx (has priority over en)
//   load_idx    load target, rejected if >= len
//   cfg_we      write table[cfg_addr] <= cfg_data
//   cfg_addr    table address
//   cfg_data    table data
//   cfg_len_we  write sequence length (0 ignored, >DEPTH clamped)
//   cfg_len     new length
//   q           table[idx], combinational read
//   idx         current index
//   len         active sequence length
//   wrap        one-cycle pulse after a wrap step
//   load_err    one-cycle pulse after a rejected load
//   t_out       (SEQ_TOGGLE_OUT_EN only) toggle vector for the next step
// -----------------------------------------------------------------------------
module seq_counter_gen #(
    parameter int WIDTH = 3,
    parameter int DEPTH = 8,
    parameter int IW    = $clog2(DEPTH),
    parameter int LW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             dir,
    input  logic             load,
    input  logic [IW-1:0]    load_idx,
    input  logic             cfg_we,
    input  logic [IW-1:0]    cfg_addr,
    input  logic [WIDTH-1:0] cfg_data,
    input  logic             cfg_len_we,
    input  logic [LW-1:0]    cfg_len,
    output logic [WIDTH-1:0] q,
    output logic [IW-1:0]    idx,
    output logic [LW-1:0]    len,
    output logic             wrap,
    output logic             load_err
`ifdef SEQ_TOGGLE_OUT_EN
    ,
    output logic [WIDTH-1:0] t_out
`endif
);

    // Common comparison width so index/length compares never truncate.
    localparam int CW = (LW > IW) ? LW : IW;
    localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);

    logic [WIDTH-1:0] table_reg [DEPTH];
    logic [DEPTH-1:0] row_we;

    logic [IW-1:0] idx_reg, idx_next;
    logic [LW-1:0] len_reg, len_next;
    logic          wrap_reg, wrap_next;
    logic          err_reg, err_next;

    logic [LW-1:0] len_m1;
    logic [IW-1:0] last_idx;
    logic [IW-1:0] fwd_idx, rev_idx, step_idx;
    logic          step_wraps;
    logic [IW-1:0] idx_cand;
    logic          wrap_cand;

    // ------------------------------------------------------------------
    // Table: per-row write enable decode. Addresses >= DEPTH match no row
    // and are therefore silently dropped.
    // ------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_row_we
            assign row_we[gi] = cfg_we && (cfg_addr == IW'(gi));
        end
    endgenerate

    // Reset restores the identity table, so q reads 0 straight after reset.
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (rst) begin
                table_reg[i] <= WIDTH'(i);
            end else if (row_we[i]) begin
                table_reg[i] <= cfg_data;
            end
        end
    end

    // ------------------------------------------------------------------
    // Step arithmetic against the current (pre-edge) length.
    // len is always >= 1, so len-1 fits in IW bits.
    // ------------------------------------------------------------------
    always_comb begin
        len_m1     = len_reg - LW'(1);
        last_idx   = IW'(len_m1);
        fwd_idx    = (idx_reg == last_idx) ? '0 : idx_reg + IW'(1);
        rev_idx    = (idx_reg == '0) ? last_idx : idx_reg - IW'(1);
        step_idx   = dir ? rev_idx : fwd_idx;
        step_wraps = dir ? (idx_reg == '0) : (idx_reg == last_idx);
    end

    // Length update: 0 is ignored, oversize values clamp to DEPTH.
    always_comb begin
        len_next = len_reg;
        if (cfg_len_we && (cfg_len != '0)) begin
            len_next = (cfg_len > DEPTH_L) ? DEPTH_L : cfg_len;
        end
    end

    // Index update: load > en. A load is validated against the length that
    // takes effect on this same edge.
    always_comb begin
        idx_cand  = idx_reg;
        wrap_cand = 1'b0;
        err_next  = 1'b0;
        if (load) begin
            if (CW'(load_idx) < CW'(len_next)) begin
                idx_cand = load_idx;
            end else begin
                err_next = 1'b1;
            end
        end else if (en) begin
            idx_cand  = step_idx;
            wrap_cand = step_wraps;
        end

        // A shrinking length that leaves idx out of range snaps idx to 0.
        // That is a re-seat rather than a sequence wrap, so no pulse.
        if (CW'(len_next) <= CW'(idx_cand)) begin
            idx_next  = '0;
            wrap_next = 1'b0;
        end else begin
            idx_next  = idx_cand;
            wrap_next = wrap_cand;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idx_reg  <= '0;
            len_reg  <= DEPTH_L;
            wrap_reg <= 1'b0;
            err_reg  <= 1'b0;
        end else begin
            idx_reg  <= idx_next;
            len_reg  <= len_next;
            wrap_reg <= wrap_next;
            err_reg  <= err_next;
        end
    end

    assign q        = table_reg[idx_reg];
    assign idx      = idx_reg;
    assign len      = len_reg;
    assign wrap     = wrap_reg;
    assign load_err = err_reg;

`ifdef SEQ_TOGGLE_OUT_EN
    logic [WIDTH-1:0] q_step;
    assign q_step = table_reg[step_idx];
    assign t_out  = (len_reg == LW'(1)) ? '0 : (q ^ q_step);
`endif

endmodule

// File: tb/tb_seq_counter_gen.sv
module tb_seq_counter_gen;

    localparam int W  = 3;
    localparam int D  = 8;
    localparam int IW = $clog2(D);
    localparam int LW = $clog2(D + 1);

    logic          clk = 1'b0;
    logic          rst;
    logic          en, dir, load;
    logic [IW-1:0] load_idx;
    logic          cfg_we;
    logic [IW-1:0] cfg_addr;
    logic [W-1:0]  cfg_data;
    logic          cfg_len_we;
    logic [LW-1:0] cfg_len;
    logic [W-1:0]  q;
    logic [IW-1:0] idx;
    logic [LW-1:0] len;
    logic          wrap, load_err;
`ifdef SEQ_TOGGLE_OUT_EN
    logic [W-1:0]  t_out;
`endif

    int n_total = 0;
    int n_pass  = 0;

    seq_counter_gen #(.WIDTH(W), .DEPTH(D)) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .dir        (dir),
        .load       (load),
        .load_idx   (load_idx),
        .cfg_we     (cfg_we),
        .cfg_addr   (cfg_addr),
        .cfg_data   (cfg_data),
        .cfg_len_we (cfg_len_we),
        .cfg_len    (cfg_len),
        .q          (q),
        .idx        (idx),
        .len        (len),
        .wrap       (wrap),
        .load_err   (load_err)
`ifdef SEQ_TOGGLE_OUT_EN
        ,
        .t_out      (t_out)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          en, dir, load;
        logic [IW-1:0] load_idx;
        logic          cfg_we;
        logic [IW-1:0] cfg_addr;
        logic [W-1:0]  cfg_data;
        logic          cfg_len_we;
        logic [LW-1:0] cfg_len;
        logic [W-1:0]  exp_q;
        logic [IW-1:0] exp_idx;
        logic [LW-1:0] exp_len;
        logic          exp_wrap, exp_err;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(
        input logic e, input logic d, input logic ld, input int li,
        input logic we, input int a, input int dat,
        input logic lwe, input int cl,
        input int eq, input int ei, input int el, input logic ew, input logic ee);
        vec_t v;
        v.en = e; v.dir = d; v.load = ld; v.load_idx = IW'(li);
        v.cfg_we = we; v.cfg_addr = IW'(a); v.cfg_data = W'(dat);
        v.cfg_len_we = lwe; v.cfg_len = LW'(cl);
        v.exp_q = W'(eq); v.exp_idx = IW'(ei); v.exp_len = LW'(el);
        v.exp_wrap = ew; v.exp_err = ee;
        return v;
    endfunction

    task automatic chk(input string nm, input int n, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s step %0d: got %0d expected %0d", nm, n, act, exp);
    endtask

    task automatic chk_all(input int n, input int eq, input int ei, input int el,
                           input logic ew, input logic ee);
        chk("q", n, int'(q), eq);
        chk("idx", n, int'(idx), ei);
        chk("len", n, int'(len), el);
        chk("wrap", n, int'(wrap), int'(ew));
        chk("load_err", n, int'(load_err), int'(ee));
    endtask

    task automatic idle_inputs();
        en = 0; dir = 0; load = 0; load_idx = '0;
        cfg_we = 0; cfg_addr = '0; cfg_data = '0;
        cfg_len_we = 0; cfg_len = '0;
    endtask

    task automatic drive(input vec_t v);
        en = v.en; dir = v.dir; load = v.load; load_idx = v.load_idx;
        cfg_we = v.cfg_we; cfg_addr = v.cfg_addr; cfg_data = v.cfg_data;
        cfg_len_we = v.cfg_len_we; cfg_len = v.cfg_len;
    endtask

    initial begin
        int seq_tbl[7] = '{5, 2, 7, 0, 3, 1, 6};
        int fq[8]   = '{2, 7, 0, 3, 1, 6, 5, 2};
        int fi[8]   = '{1, 2, 3, 4, 5, 6, 0, 1};
        int rq[8]   = '{5, 6, 1, 3, 0, 7, 2, 5};
        int ri[8]   = '{0, 6, 5, 4, 3, 2, 1, 0};

        // Program table and length 7.
        for (int i = 0; i < 7; i++)
            vecs.push_back(mk(0,0,0,0, 1,i,seq_tbl[i], 0,0, 5,0,8,0,0));
        vecs.push_back(mk(0,0,0,0, 0,0,0, 1,7, 5,0,7,0,0));
        // Forward 8 steps: wrap only on return to idx 0.
        for (int i = 0; i < 8; i++)
            vecs.push_back(mk(1,0,0,0, 0,0,0, 0,0, fq[i],fi[i],7, fi[i] == 0, 0));
        // Reverse from idx 1: wrap on 0 -> 6.
        for (int i = 0; i < 8; i++)
            vecs.push_back(mk(1,1,0,0, 0,0,0, 0,0, rq[i],ri[i],7, i == 1, 0));
        vecs.push_back(mk(0,0,0,0, 0,0,0, 0,0, 5,0,7,0,0));   // hold
        vecs.push_back(mk(1,0,1,4, 0,0,0, 0,0, 3,4,7,0,0));   // load beats en
        vecs.push_back(mk(0,0,1,7, 0,0,0, 0,0, 3,4,7,0,1));   // rejected load
        vecs.push_back(mk(0,0,0,0, 0,0,0, 0,0, 3,4,7,0,0));   // err clears
        vecs.push_back(mk(0,0,1,5, 0,0,0, 0,0, 1,5,7,0,0));
        vecs.push_back(mk(0,0,0,0, 0,0,0, 1,3, 5,0,3,0,0));   // shrink re-seats idx
        vecs.push_back(mk(0,0,0,0, 0,0,0, 1,0, 5,0,3,0,0));   // len 0 ignored
        vecs.push_back(mk(0,0,0,0, 0,0,0, 1,9, 5,0,8,0,0));   // clamp to DEPTH
        vecs.push_back(mk(0,0,1,5, 0,0,0, 1,4, 5,0,4,0,1));   // load vs new len
        vecs.push_back(mk(0,0,0,0, 0,0,0, 1,1, 5,0,1,0,0));
        vecs.push_back(mk(1,0,0,0, 0,0,0, 0,0, 5,0,1,1,0));   // len 1 fwd wraps
        vecs.push_back(mk(1,1,0,0, 0,0,0, 0,0, 5,0,1,1,0));   // len 1 rev wraps
        vecs.push_back(mk(0,0,0,0, 0,0,0, 1,8, 5,0,8,0,0));
        vecs.push_back(mk(0,0,0,0, 1,0,4, 0,0, 4,0,8,0,0));   // write at current idx
        vecs.push_back(mk(0,0,1,5, 0,0,0, 0,0, 1,5,8,0,0));
        vecs.push_back(mk(1,0,0,0, 0,0,0, 1,3, 4,0,3,0,0));   // step 5->6 then re-seat
        vecs.push_back(mk(1,0,0,0, 0,0,0, 0,0, 2,1,3,0,0));
        vecs.push_back(mk(1,0,0,0, 0,0,0, 0,0, 7,2,3,0,0));
        vecs.push_back(mk(1,0,0,0, 0,0,0, 0,0, 4,0,3,1,0));
        vecs.push_back(mk(0,0,0,0, 0,0,0, 1,8, 4,0,8,0,0));
        vecs.push_back(mk(0,0,1,3, 0,0,0, 0,0, 0,3,8,0,0));   // park at idx 3

        // Reset state.
        idle_inputs();
        rst = 1;
        repeat (2) @(posedge clk);
        #1;
        chk_all(-1, 0, 0, 8, 0, 0);
        rst = 0;

        foreach (vecs[i]) begin
            drive(vecs[i]);
            @(posedge clk);
            #1;
            $display("vec %0d: q=%0d idx=%0d len=%0d wrap=%0d err=%0d", i, q, idx, len, wrap, load_err);
            chk_all(i, int'(vecs[i].exp_q), int'(vecs[i].exp_idx), int'(vecs[i].exp_len),
                    vecs[i].exp_wrap, vecs[i].exp_err);
        end

        // Reset mid-count with en and load asserted: reset wins.
        en = 1; load = 1; load_idx = IW'(5); rst = 1;
        @(posedge clk);
        #1;
        $display("mid-count reset: q=%0d idx=%0d len=%0d wrap=%0d", q, idx, len, wrap);
        chk_all(100, 0, 0, 8, 0, 0);
        rst = 0; load = 0; dir = 0;
        // Identity table restored: forward walk reads q = idx.
        for (int i = 1; i <= 8; i++) begin
            @(posedge clk);
            #1;
            $display("identity step %0d: q=%0d idx=%0d wrap=%0d", i, q, idx, wrap);
            chk_all(100 + i, i % 8, i % 8, 8, i == 8, 0);
        end
        idle_inputs();

`ifdef SEQ_TOGGLE_OUT_EN
        for (int i = 0; i < 7; i++) begin
            cfg_we = 1; cfg_addr = IW'(i); cfg_data = W'(seq_tbl[i]);
            @(posedge clk);
        end
        cfg_we = 0; cfg_len_we = 1; cfg_len = LW'(7);
        @(posedge clk);
        cfg_len_we = 0;
        begin
            int tl_idx[3] = '{0, 2, 4};
            int tl_exp[3] = '{7, 7, 2};
            for (int i = 0; i < 3; i++) begin
                load = 1; load_idx = IW'(tl_idx[i]); dir = 0;
                @(posedge clk);
                #1;
                load = 0;
                $display("toggle at idx %0d: q=%0d t_out=%0d", idx, q, t_out);
                chk("t_out", 200 + i, int'(t_out), tl_exp[i]);
            end
        end
        cfg_len_we = 1; cfg_len = LW'(1);
        @(posedge clk);
        #1;
        cfg_len_we = 0;
        chk("t_out_len1", 210, int'(t_out), 0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
